mem_wb_pipe_reg: RTL
====================

// Module: mem_wb_pipe_reg
// PURPOSE
//  Parametrised MEM->WB pipeline stage register with valid/ready handshake, freeze and flush.
//  Carries WB_EN, MEM_R_EN, destination, ALU result and memory read data into writeback.
//  Adds a pre-muxed writeback value; optional 2-entry skid buffer decouples in_ready timing.
//  Sits between the data-memory/cache stage and the register-file write port.
// PARAMETERS
//  DATA_W  32  width of ALU result, memory data and writeback value
//  DEST_W  4   width of destination register index
// PORTS
//  clk           in   1       clock, rising edge
//  rst           in   1       reset, asynchronous, active-high
//  freeze        in   1       stall (e.g. cache miss): hold all state, no accept, no drain
//  flush         in   1       synchronous flush: drop all held entries
//  in_valid      in   1       upstream entry valid
//  in_ready      out  1       stage can accept this cycle
//  in_wb_en      in   1       entry writes register file
//  in_mem_r_en   in   1       entry is a load
//  in_dest       in   DEST_W  destination register
//  in_alu_res    in   DATA_W  ALU result / address
//  in_mem_data   in   DATA_W  memory read data
//  out_valid     out  1       head entry valid
//  out_ready     in   1       writeback consumes head this cycle
//  out_wb_en     out  1       head wb_en AND out_valid
//  out_mem_r_en  out  1       head mem_r_en
//  out_dest      out  DEST_W  head destination
//  out_alu_res   out  DATA_W  head ALU result
//  out_mem_data  out  DATA_W  head memory data
//  out_wb_value  out  DATA_W  out_mem_r_en ? out_mem_data : out_alu_res (combinational)
// BEHAVIOUR
//  - Reset (async): all entries invalid, all payload regs 0; every output 0 incl. in_ready.
//    in_ready may rise only from the first clk edge after rst deasserts.
//  - Accept = in_valid & in_ready & ~freeze & ~flush. Drain = out_valid & out_ready & ~freeze & ~flush.
//  - Priority: rst > flush > freeze > normal. flush: all entries invalid next cycle, payload
//    may keep stale data, an input offered the same cycle is dropped.
//  - freeze: state and outputs unchanged; in_ready forced 0; out_ready ignored.
//  - out_wb_en is 0 whenever out_valid is 0 (no spurious RF write).
//  - Latency: accepted entry appears on out_* on the next rising edge (1 cycle). Order preserved.
//  - Simultaneous accept+drain: head replaced by new entry, no bubble, no loss.
//  - Widths: payload copied unmodified; no arithmetic.
// CONFIGURATION
//  Macro MEM_WB_SKID_EN.
//  Defined: 2 slots (main, skid); state EMPTY/ONE/TWO.
//    EMPTY -acc-> ONE; ONE -acc&~drn-> TWO (entry to skid); ONE -drn&~acc-> EMPTY;
//    ONE -acc&drn-> ONE (main reloaded); TWO -drn-> ONE (skid moves to main; no accept).
//    in_ready is a register: 1 in EMPTY/ONE after reset release, 0 in TWO or while freeze.
//    Full: TWO with out_ready=0 holds indefinitely, nothing lost. flush -> EMPTY.
//  Undefined: single slot; in_ready = ~rst_done? no: in_ready = ~freeze & ~flush &
//    (~out_valid | out_ready) combinational (0 during reset); transitions EMPTY<->ONE only.
//  Both builds give identical output sequences for identical accepted streams.
// TESTING
//  1 Reset: rst=1 mid-stream with entry held -> all outputs 0 immediately; clk edge after
//    release -> in_ready=1, out_valid=0.
//  2 Load pass: in dest=4'h3, alu=32'h100, mem=32'hDEAD_BEEF, mem_r_en=1, wb_en=1 ->
//    next cycle out_valid=1, out_wb_value=32'hDEAD_BEEF; with mem_r_en=0 -> 32'h100.
//  3 Back-pressure: stream 1,2,3 with out_ready=0 -> SKID build: in_ready=0 after 2 accepted,
//    out holds 1; release -> 1,2,3 in order; NON-SKID: in_ready=0 after 1.
//  4 Freeze: freeze=1 for 5 cycles with out_ready=1, in_valid=1 -> outputs frozen, no accept,
//    no drain; resume -> stream continues without loss or duplication.
//  5 Flush: TWO entries held, flush=1 with in_valid=1 -> next cycle out_valid=0, out_wb_en=0,
//    offered entry dropped; following entry accepted normally.
//  6 Full throughput: in_valid=out_ready=1 for 100 cycles, random payload -> 1 entry/cycle,
//    scoreboard match, out_wb_en never 1 with out_valid 0.

Source files
------------

// File: rtl/mem_wb_pipe_reg.sv
// -----------------------------------------------------------------------------
// mem_wb_pipe_reg
//
// MEM->WB pipeline stage register with a valid/ready handshake, freeze and
// flush. Carries wb_en, mem_r_en, destination, ALU result and memory read data
// into writeback. It also presents a pre-muxed writeback value, which is the
// load data for loads and the ALU result otherwise.
//
// Build option:
//   MEM_WB_SKID_EN  defined   -> two slots (main + skid). in_ready comes from a
//                                register, so it does not depend on out_ready
//                                in the same cycle.
//                   undefined -> single slot. in_ready is combinational:
//                                ~freeze & ~flush & (~out_valid | out_ready).
//   Both builds produce the same output sequence for the same accepted stream.
//
// Parameters:
//   DATA_W  width of ALU result, memory data and writeback value
//   DEST_W  width of destination register index
//
// Ports:
//   clk, rst        rising-edge clock; asynchronous active-high reset
//   freeze          stall: hold all state, accept nothing, drain nothing
//   flush           synchronous drop of every held entry
//   in_valid/ready  upstream handshake
//   in_*            incoming entry payload
//   out_valid/ready writeback handshake on the head entry
//   out_*           head entry payload; out_wb_en is qualified by out_valid
//   out_wb_value    out_mem_r_en ? out_mem_data : out_alu_res
// -----------------------------------------------------------------------------
module mem_wb_pipe_reg #(
    parameter int DATA_W = 32,
    parameter int DEST_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_wb_en,
    input  logic              in_mem_r_en,
    input  logic [DEST_W-1:0] in_dest,
    input  logic [DATA_W-1:0] in_alu_res,
    input  logic [DATA_W-1:0] in_mem_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_wb_en,
    output logic              out_mem_r_en,
    output logic [DEST_W-1:0] out_dest,
    output logic [DATA_W-1:0] out_alu_res,
    output logic [DATA_W-1:0] out_mem_data,
    output logic [DATA_W-1:0] out_wb_value
);

    typedef struct packed {
        logic              wb_en;
        logic              mem_r_en;
        logic [DEST_W-1:0] dest;
        logic [DATA_W-1:0] alu_res;
        logic [DATA_W-1:0] mem_data;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t state_q;
    entry_t main_q;      // head entry, always the one shown on out_*
    entry_t in_entry;
    logic   accept;
    logic   drain;

    assign in_entry = {in_wb_en, in_mem_r_en, in_dest, in_alu_res, in_mem_data};

    assign out_valid = (state_q != EMPTY);
    assign accept    = in_valid  & in_ready  & ~freeze & ~flush;
    assign drain     = out_valid & out_ready & ~freeze & ~flush;

`ifdef MEM_WB_SKID_EN

    entry_t skid_q;      // second-oldest entry, valid only in TWO
    logic   in_ready_q;
    state_t state_d;

    // NOTE: every variable assigned in always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = EMPTY;
        end else if (!freeze) begin
            case (state_q)
                EMPTY: if (accept) state_d = ONE;
                ONE: begin
                    if (accept && !drain)      state_d = TWO;
                    else if (drain && !accept) state_d = EMPTY;
                end
                TWO:     if (drain) state_d = ONE;
                default: state_d = EMPTY;
            endcase
        end
    end

    // Registered readiness; freeze only masks it so an upstream stall never
    // leaks an accept.
    assign in_ready = in_ready_q & ~freeze;

    // NOTE: the payload registers sit on the async reset as well as the
    // control state, so every output reads 0 during reset, not just out_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so every register here samples
            // the pre-edge values, e.g. main_q <= skid_q sees the old skid.
            state_q    <= state_d;
            // Readiness follows the next state. in_ready_q is still 0 in the
            // first cycle after reset release and rises on the first edge.
            in_ready_q <= (state_d != TWO);
            if (accept) begin
                // An empty stage, or a head that leaves this cycle, takes the
                // new entry straight into main. Otherwise it queues behind.
                if (state_q == EMPTY || drain) main_q <= in_entry;
                else                           skid_q <= in_entry;
            end else if (drain && state_q == TWO) begin
                main_q <= skid_q;
            end
        end
    end

`else

    logic rst_done_q;    // keeps in_ready low until the first edge after reset

    assign in_ready = rst_done_q & ~freeze & ~flush & (~out_valid | out_ready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= EMPTY;
            main_q     <= '0;
            rst_done_q <= 1'b0;
        end else begin
            rst_done_q <= 1'b1;
            if (flush) begin
                state_q <= EMPTY;   // payload intentionally left stale
            end else if (accept) begin
                state_q <= ONE;     // covers accept with and without drain
                main_q  <= in_entry;
            end else if (drain) begin
                state_q <= EMPTY;
            end
        end
    end

`endif

    // Qualify wb_en so that a stale payload after a flush cannot trigger a
    // register-file write.
    assign out_wb_en    = main_q.wb_en & out_valid;
    assign out_mem_r_en = main_q.mem_r_en;
    assign out_dest     = main_q.dest;
    assign out_alu_res  = main_q.alu_res;
    assign out_mem_data = main_q.mem_data;
    assign out_wb_value = main_q.mem_r_en ? main_q.mem_data : main_q.alu_res;

endmodule
